// File: rtl/gpio_seg_scan_pkg.sv
// Shared 7-segment types and active-low glyph table for the GPIO hex display scanner.
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'h7F;

  // Patterns are {g,f,e,d,c,b,a}, active-low, indexed by nibble value
  localparam seg_t SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/gpio_seg_scan_if.sv
// Bundle between the GPIO output port / mask source and the display scanner pins.
interface gpio_seg_scan_if
  import seg_pkg::*;
#(
  parameter int N_DIGITS = 8
);

  logic [31:0]         data_in;
  logic [N_DIGITS-1:0] blank_mask;
  logic [N_DIGITS-1:0] dp_mask;
  logic [N_DIGITS-1:0] an;
  seg_t                seg;
  logic                dp;
  logic                frame_tick;

  modport master (
    output data_in, blank_mask, dp_mask,
    input  an, seg, dp, frame_tick
  );

  modport slave (
    input  data_in, blank_mask, dp_mask,
    output an, seg, dp, frame_tick
  );

endinterface

// File: rtl/gpio_seg_scan_hex7seg.sv
// Combinational nibble to active-low 7-segment decoder with a forced-dark input.
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output seg_t       seg
);

  // Glyph lookup, overridden when the digit is dark
  always_comb begin
    if (blank) begin
      seg = SEG_OFF;
    end else begin
      seg = SEG_HEX[nibble];
    end
  end

endmodule

// File: rtl/gpio_seg_scan.sv
// Time-multiplexed hex display of a GPIO word with a frame-synchronous shadow register.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module gpio_seg_scan
  import seg_pkg::*;
#(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
)(
  input  logic              clk,
  input  logic              rst,
  gpio_seg_scan_if.slave    bus
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int DW    = 4 * N_DIGITS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [CNT_W-1:0]    cnt_r;
  logic [IDX_W-1:0]    idx_r;
  logic [DW-1:0]       shadow_data_r;
  logic [N_DIGITS-1:0] shadow_blank_r;
  logic [N_DIGITS-1:0] shadow_dp_r;
  logic [N_DIGITS-1:0] an_r;
  seg_t                seg_r;
  logic                dp_r;
  logic                frame_tick_r;

  logic                cnt_wrap_s;
  logic                frame_end_s;
  logic [3:0]          nibble_s;
  logic [N_DIGITS-1:0] lz_s;
  logic [N_DIGITS-1:0] an_s;
  logic                dark_s;
  logic                dp_s;
  seg_t                seg_dec_s;

  assign cnt_wrap_s  = (cnt_r == CNT_LAST);
  assign frame_end_s = cnt_wrap_s && (idx_r == IDX_LAST);

  // Refresh divider and digit scan index
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r <= {CNT_W{1'b0}};
      idx_r <= {IDX_W{1'b0}};
    end else if (cnt_wrap_s) begin
      cnt_r <= {CNT_W{1'b0}};
      idx_r <= (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Frame snapshot: inputs are only sampled on the last cycle of the last digit
  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow_data_r  <= {DW{1'b0}};
      shadow_blank_r <= {N_DIGITS{1'b0}};
      shadow_dp_r    <= {N_DIGITS{1'b0}};
      frame_tick_r   <= 1'b0;
    end else begin
      frame_tick_r <= frame_end_s;
      if (frame_end_s) begin
        shadow_data_r  <= bus.data_in[DW-1:0];
        shadow_blank_r <= bus.blank_mask;
        shadow_dp_r    <= bus.dp_mask;
      end
    end
  end

`ifdef SEG_LZB_EN
  // Zero digits above the highest nonzero nibble go dark; digit 0 always shows
  function automatic logic [N_DIGITS-1:0] lead_zero_mask(input logic [DW-1:0] word);
    logic seen;
    lead_zero_mask = {N_DIGITS{1'b0}};
    seen           = 1'b0;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      if (word[4*i +: 4] != 4'h0) begin
        seen = 1'b1;
      end else begin
        seen = seen;
      end
      lead_zero_mask[i] = ~seen;
    end
  endfunction

  assign lz_s = lead_zero_mask(shadow_data_r);
`else
  assign lz_s = {N_DIGITS{1'b0}};
`endif

  assign nibble_s = shadow_data_r[{idx_r, 2'b00} +: 4];

  hex7seg u_hex7seg (
    .nibble (nibble_s),
    .blank  (dark_s),
    .seg    (seg_dec_s)
  );

  // Next-output selection for the digit currently indexed
  always_comb begin
    an_s        = {N_DIGITS{1'b1}};
    an_s[idx_r] = 1'b0;
    dark_s      = shadow_blank_r[idx_r] | lz_s[idx_r];
    if (shadow_blank_r[idx_r]) begin
      dp_s = 1'b1;
    end else begin
      dp_s = ~shadow_dp_r[idx_r];
    end
  end

  // Registered display pins
  always_ff @(posedge clk) begin
    if (!rst) begin
      an_r  <= {N_DIGITS{1'b1}};
      seg_r <= SEG_OFF;
      dp_r  <= 1'b1;
    end else begin
      an_r  <= an_s;
      seg_r <= seg_dec_s;
      dp_r  <= dp_s;
    end
  end

  assign bus.an         = an_r;
  assign bus.seg        = seg_r;
  assign bus.dp         = dp_r;
  assign bus.frame_tick = frame_tick_r;

endmodule

// File: tb/tb_gpio_seg_scan.sv
// Directed bench: 8-digit scanner at REFRESH_DIV=4 plus a 4-digit REFRESH_DIV=1 instance.
module tb_gpio_seg_scan;
  import seg_pkg::*;

  typedef struct packed {
    logic [31:0]     data;
    logic [7:0]      blank;
    logic [7:0]      dpm;
    logic [7:0][6:0] segs;
    logic [7:0]      dps;
  } vec_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  gpio_seg_scan_if #(.N_DIGITS(8)) bus ();
  gpio_seg_scan_if #(.N_DIGITS(4)) sbus ();

  gpio_seg_scan #(.N_DIGITS(8), .REFRESH_DIV(4), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  gpio_seg_scan #(.N_DIGITS(4), .REFRESH_DIV(1), .CNT_W(1)) dut_fast (
    .clk (clk),
    .rst (rst),
    .bus (sbus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.data_in    = v.data;
    bus.blank_mask = v.blank;
    bus.dp_mask    = v.dpm;
  endtask

  // Entered just after a negedge where frame_tick=1 (or right after reset release)
  task automatic check_frame(input string tag, input vec_t e, input vec_t nxt);
    int d;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      d = c / 4;
      check($sformatf("%s an c%0d", tag, c), {24'h0, bus.an}, {24'h0, ~(8'h01 << d)});
      check($sformatf("%s seg d%0d", tag, d), {25'h0, bus.seg}, {25'h0, e.segs[d]});
      check($sformatf("%s dp d%0d", tag, d), {31'h0, bus.dp}, {31'h0, e.dps[d]});
      check($sformatf("%s tick c%0d", tag, c), {31'h0, bus.frame_tick}, {31'h0, (c == 31)});
      if (c == 16) drive(nxt);
    end
  endtask

  vec_t vecs [7];
  vec_t zero_rec;
  logic found;

  initial begin
    n_cmp = 0;
    n_err = 0;

`ifdef SEG_LZB_EN
    zero_rec = '{32'h0, 8'h00, 8'h00, {{7{7'h7F}}, 7'h40}, 8'hFF};
    vecs[1]  = '{32'h0000_00CC, 8'h00, 8'h00, {{6{7'h7F}}, 7'h46, 7'h46}, 8'hFF};
    vecs[2]  = '{32'h0000_000F, 8'h00, 8'h00, {{7{7'h7F}}, 7'h0E}, 8'hFF};
    vecs[5]  = '{32'h0000_0100, 8'h00, 8'h80, {{5{7'h7F}}, 7'h79, 7'h40, 7'h40}, 8'h7F};
`else
    zero_rec = '{32'h0, 8'h00, 8'h00, {8{7'h40}}, 8'hFF};
    vecs[1]  = '{32'h0000_00CC, 8'h00, 8'h00, {{6{7'h40}}, 7'h46, 7'h46}, 8'hFF};
    vecs[2]  = '{32'h0000_000F, 8'h00, 8'h00, {{7{7'h40}}, 7'h0E}, 8'hFF};
    vecs[5]  = '{32'h0000_0100, 8'h00, 8'h80, {{5{7'h40}}, 7'h79, 7'h40, 7'h40}, 8'h7F};
`endif
    vecs[0] = '{32'h6666_6666, 8'h00, 8'h00, {8{7'h02}}, 8'hFF};
    vecs[3] = '{32'h1234_5678, 8'h0F, 8'h10,
                {7'h79, 7'h24, 7'h30, 7'h19, 7'h7F, 7'h7F, 7'h7F, 7'h7F}, 8'hEF};
    vecs[4] = '{32'h89AB_CDEF, 8'h00, 8'hA5,
                {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}, 8'h5A};
    vecs[6] = zero_rec;

    // Fast instance: REFRESH_DIV=1, 4 digits, upper data bits must be ignored
    rst = 1'b0;
    drive(vecs[0]);
    sbus.data_in    = 32'hABCD_4321;
    sbus.blank_mask = 4'h0;
    sbus.dp_mask    = 4'h2;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (sbus.frame_tick) found = 1'b1;
    end
    check("fast tick seen", {31'h0, found}, 32'h1);
    begin
      logic [3:0] an_exp [4];
      logic [6:0] seg_exp [4];
      an_exp  = '{4'hE, 4'hD, 4'hB, 4'h7};
      seg_exp = '{7'h79, 7'h24, 7'h30, 7'h19};
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        check($sformatf("fast an d%0d", c), {28'h0, sbus.an}, {28'h0, an_exp[c]});
        check($sformatf("fast seg d%0d", c), {25'h0, sbus.seg}, {25'h0, seg_exp[c]});
        check($sformatf("fast dp d%0d", c), {31'h0, sbus.dp}, {31'h0, (c != 1)});
        check($sformatf("fast tick c%0d", c), {31'h0, sbus.frame_tick}, {31'h0, (c == 3)});
      end
    end

    // Main reset held 3 cycles with nonzero data present
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst an", {24'h0, bus.an}, 32'hFF);
    check("rst seg", {25'h0, bus.seg}, 32'h7F);
    check("rst dp", {31'h0, bus.dp}, 32'h1);
    check("rst tick", {31'h0, bus.frame_tick}, 32'h0);
    rst = 1'b1;

    // Frame 0 shows the zeroed shadow, not data_in
    check_frame("frame0", zero_rec, vecs[0]);
    for (int k = 0; k < 7; k++) begin
      check_frame($sformatf("vec%0d", k), vecs[k], vecs[(k < 6) ? k + 1 : 6]);
    end

    // Reset pulse while digit 5 is active
    drive(vecs[4]);
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (bus.an == 8'hDF) found = 1'b1;
    end
    check("digit5 reached", {31'h0, found}, 32'h1);
    rst = 1'b0;
    @(negedge clk);
    check("midrst an", {24'h0, bus.an}, 32'hFF);
    check("midrst seg", {25'h0, bus.seg}, 32'h7F);
    check("midrst dp", {31'h0, bus.dp}, 32'h1);
    check("midrst tick", {31'h0, bus.frame_tick}, 32'h0);
    rst = 1'b1;
    check_frame("post_rst", zero_rec, vecs[4]);
    check_frame("post_rst1", vecs[4], vecs[4]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
